// File: rtl/instr_fetch.sv
// Instruction fetch: reads a 32-word ROM, presents decoded instructions
// over a valid/ready handshake and resolves BR in the fetch stage.
// Ports: clk, reset (sync, active-high); rom_address/rom_cs/rom_data;
// instr_valid/instr_ready, opcode, operand, instr_pc, illegal_op.
// Optional macro ILLEGAL_OP_TRAP_EN: opcodes 0xA-0xF halt the fetcher.
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  rom_address,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  opcode,
  output logic [15:0] operand,
  output logic [4:0]  instr_pc,
  output logic        illegal_op
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  pc;
  logic [4:0]  pc_nxt;
  logic        fetch;
  logic        is_br;
  logic        is_ill;
  logic        unused_bits;

  assign unused_bits = ^rom_data[27:16];

  // Fetch whenever running and the output slot is free or being drained.
  assign fetch = (state == RUN) && (!instr_valid || instr_ready);
  assign is_br = (rom_data[31:28] == 4'h8);

`ifdef ILLEGAL_OP_TRAP_EN
  logic ill_q;

  assign is_ill     = (rom_data[31:28] >= 4'hA);
  assign illegal_op = ill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ill_q <= 1'b0;
    end else if (fetch) begin
      ill_q <= is_ill;
    end
  end
`else
  assign is_ill     = 1'b0;
  assign illegal_op = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: HALT is sticky until reset
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (fetch && is_ill) state_nxt = HALT;
      HALT: state_nxt = HALT;
    endcase
  end

  // Outputs
  always_comb begin
    rom_cs = fetch && !reset;
  end

  assign rom_address = pc;

  // Illegal fetch freezes PC on the trapping address.
  always_comb begin
    pc_nxt = pc;
    if (fetch && !is_ill) begin
      pc_nxt = is_br ? rom_data[4:0] : pc + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 5'd0;
      instr_valid <= 1'b0;
      opcode      <= 4'd0;
      operand     <= 16'd0;
      instr_pc    <= 5'd0;
    end else begin
      pc <= pc_nxt;
      if (fetch) begin
        instr_valid <= 1'b1;
        opcode      <= rom_data[31:28];
        operand     <= rom_data[15:0];
        instr_pc    <= pc;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide rom_address, output, 5 bits: ROM word address, always equal to the internal PC.
REQ-004 SHALL provide rom_cs, output, 1 bit: ROM chip select, high only in fetch cycles.
REQ-005 SHALL provide rom_data, input, 32 bits: ROM word, combinationally valid in the same cycle as rom_address/rom_cs.
REQ-006 SHALL provide instr_valid, output, 1 bit: a decoded instruction is presented.
REQ-007 SHALL provide instr_ready, input, 1 bit: the executor consumes the instruction when instr_valid && instr_ready.
REQ-008 SHALL provide opcode, output, 4 bits: rom_data[31:28] of the presented instruction.
REQ-009 SHALL provide operand, output, 16 bits: rom_data[15:0] of the presented instruction; rom_data[27:16] is ignored.
REQ-010 SHALL provide instr_pc, output, 5 bits: address the presented instruction was fetched from.
REQ-011 SHALL provide illegal_op, output, 1 bit: the presented opcode is illegal (see Configuration).

Function
REQ-012 SHALL define a fetch cycle as any cycle with state RUN && (!instr_valid || instr_ready); rom_cs SHALL equal this condition.
REQ-013 SHALL, on a fetch cycle, register opcode/operand from rom_data, instr_pc<=PC, and instr_valid<=1: one-cycle latency, one instruction per cycle with instr_ready held high.
REQ-014 SHALL, on a fetch cycle, set next PC to rom_data[4:0] if rom_data[31:28]==4'h8 (BR, resolved in fetch; operand[15:5] ignored), else PC+1 modulo 32 (0x1F wraps to 0x00).
REQ-015 SHALL still present a fetched BR to the executor like any other instruction.
REQ-016 SHALL hold opcode, operand, instr_pc, illegal_op and PC stable while instr_valid && !instr_ready.
REQ-017 SHALL clear instr_valid after consumption only when the next cycle is not a fetch cycle (HALT state).
REQ-018 SHALL treat opcode 0 (NOP) and opcodes 1-9 as legal and present them unchanged.
REQ-019 SHALL implement states RUN and HALT; HALT is entered only per REQ-024 and left only by reset.

Reset
REQ-020 SHALL, while reset is high at a clock edge: PC=0, state=RUN, instr_valid=0, opcode=0, operand=0, instr_pc=0, illegal_op=0; reset overrides any fetch or handshake in that cycle.
REQ-021 SHALL drive rom_cs=0 during reset; the first fetch (address 0) occurs in the first cycle after reset deasserts.

Configuration
REQ-022 SHALL gate the illegal-opcode trap with macro ILLEGAL_OP_TRAP_EN.
REQ-023 SHALL, without ILLEGAL_OP_TRAP_EN, present opcodes 0xA-0xF as ordinary instructions, tie illegal_op to 0, and never leave RUN.
REQ-024 SHALL, with ILLEGAL_OP_TRAP_EN, on fetching opcode 0xA-0xF: present it with illegal_op=1, enter HALT, freeze PC, and issue no further rom_cs; the instruction stays valid until consumed, after which instr_valid=0 until reset.

Verification
REQ-025 SHALL test reset release with instr_ready=1 and the standard program (0x00 LI 000f ... 0x14 BR 0) -> cycle 1: valid=1, opcode=4, operand=000f, instr_pc=0; instr_pc steps 0..0x14, then 0x00.
REQ-026 SHALL test instr_ready low for 3 cycles while instr_pc=0x02 -> outputs stable, rom_cs=0, rom_address=0x03 held; instr_pc=0x03 one cycle after ready returns high.
REQ-027 SHALL test a non-branch word at 0x1F -> next instr_pc=0x00 (wrap).
REQ-028 SHALL test BR with operand 0x0025 -> next fetched address 0x05.
REQ-029 SHALL test reset pulsed while valid=1 at instr_pc=0x07 -> next cycle valid=0, rom_cs=0; after release, fetch from 0x00.
REQ-030 SHALL test opcode 0xA at 0x03 -> with macro: illegal_op=1, rom_cs stays 0, valid drops after consumption; without macro: illegal_op=0 and fetch continues at 0x04.
